// File: rtl/alsu_pkg.sv
// Shared ALSU constants, op-select codes and scheduler state encoding.
package alsu_pkg;

    localparam int unsigned ALSU_DATA_W = 4;
    localparam int unsigned ALSU_SEL_W  = 4;

    localparam logic [ALSU_SEL_W-1:0] SEL_ADD = 4'b0000;
    localparam logic [ALSU_SEL_W-1:0] SEL_INC = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    // Only add and increment produce a carry worth reporting.
    function automatic logic carry_op(input logic [ALSU_SEL_W-1:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_INC);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches i_req starting at i_ptr and
// returns a one-hot grant, the grant index and an any-grant flag.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [ID_W-1:0]    o_grant_idx_c,
    output logic               o_any_grant_c
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        o_any_grant_c = 1'b0;
        w_idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any_grant_c && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_grant_idx_c    = w_idx;
                o_any_grant_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alsu_request_scheduler.sv
// Round-robin scheduler sharing one ALSU between NUM_REQ requesters.
// Optional Rsp_Zero output is enabled by defining ALSU_SCHED_ZERO_FLAG_EN.
module alsu_request_scheduler
    import alsu_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned DATA_W   = ALSU_DATA_W,
    parameter int unsigned SEL_W    = ALSU_SEL_W,
    parameter int unsigned ALSU_LAT = 1,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        Req_Valid,
    output logic [NUM_REQ-1:0]        Req_Ready,
    input  logic [NUM_REQ*SEL_W-1:0]  Req_Sel,
    input  logic [NUM_REQ*DATA_W-1:0] Req_A,
    input  logic [NUM_REQ*DATA_W-1:0] Req_B,
    output logic [SEL_W-1:0]          ALSU_Sel,
    output logic [DATA_W-1:0]         ALSU_A,
    output logic [DATA_W-1:0]         ALSU_B,
    input  logic [DATA_W-1:0]         ALSU_Result,
    input  logic                      ALSU_Carry_Out,
    output logic                      Rsp_Valid,
    input  logic                      Rsp_Ready,
    output logic [ID_W-1:0]           Rsp_Id,
    output logic [DATA_W-1:0]         Rsp_Result,
    output logic                      Rsp_Carry_Out,
`ifdef ALSU_SCHED_ZERO_FLAG_EN
    output logic                      Rsp_Zero,
`endif
    output logic                      Busy
);

    localparam int unsigned CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

    sched_state_e       r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_lat_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any_grant;
    logic               w_req_hs;
    logic               w_carry_op;
    logic [SEL_W-1:0]   w_sel;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [ID_W-1:0]    w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req         (Req_Valid),
        .i_ptr         (r_ptr),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_grant_idx),
        .o_any_grant_c (w_any_grant)
    );

    // Ready must follow Req_Valid in the same cycle, so it is decoded from state.
    assign w_req_hs  = w_any_grant && (r_state == IDLE);
    assign Req_Ready = (w_req_hs && !RST) ? w_grant : '0;
    assign Busy      = (r_state != IDLE);

    assign w_carry_op = carry_op(ALSU_SEL_W'(ALSU_Sel));
    assign w_ptr_next = (Rsp_Id == ID_W'(NUM_REQ - 1)) ? '0 : Rsp_Id + ID_W'(1);

    // Operand mux for the granted requester.
    always_comb begin
        w_sel = '0;
        w_a   = '0;
        w_b   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel = Req_Sel[i*SEL_W +: SEL_W];
                w_a   = Req_A[i*DATA_W +: DATA_W];
                w_b   = Req_B[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_lat_cnt     <= '0;
            ALSU_Sel      <= '0;
            ALSU_A        <= '0;
            ALSU_B        <= '0;
            Rsp_Valid     <= 1'b0;
            Rsp_Id        <= '0;
            Rsp_Result    <= '0;
            Rsp_Carry_Out <= 1'b0;
`ifdef ALSU_SCHED_ZERO_FLAG_EN
            Rsp_Zero      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_hs) begin
                        ALSU_Sel  <= w_sel;
                        ALSU_A    <= w_a;
                        ALSU_B    <= w_b;
                        Rsp_Id    <= w_grant_idx;
                        r_lat_cnt <= CNT_W'(ALSU_LAT - 1);
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_lat_cnt == '0) begin
                        Rsp_Result    <= ALSU_Result;
                        Rsp_Carry_Out <= w_carry_op & ALSU_Carry_Out;
`ifdef ALSU_SCHED_ZERO_FLAG_EN
                        Rsp_Zero      <= (ALSU_Result == '0);
`endif
                        Rsp_Valid     <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        Rsp_Valid <= 1'b0;
                        r_ptr     <= w_ptr_next;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_request_scheduler.sv
// Directed scoreboard bench for alsu_request_scheduler (ALSU_LAT=1 and ALSU_LAT=3 instances).
module tb_alsu_request_scheduler;

    typedef struct {
        logic       id;
        logic [3:0] res;
        logic       carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    logic exp_ptr;
    logic fc;

    // ---------------- ALSU_LAT=1 instance ----------------
    logic [3:0] t_sel [2];
    logic [3:0] t_a   [2];
    logic [3:0] t_b   [2];
    logic [1:0] Req_Valid, Req_Ready;
    logic [7:0] Req_Sel, Req_A, Req_B;
    logic [3:0] ALSU_Sel, ALSU_A, ALSU_B, ALSU_Result, Rsp_Result;
    logic       ALSU_Carry_Out, Rsp_Valid, Rsp_Ready, Rsp_Carry_Out, Busy;
    logic [0:0] Rsp_Id;
`ifdef ALSU_SCHED_ZERO_FLAG_EN
    logic       Rsp_Zero;
`endif

    assign Req_Sel = {t_sel[1], t_sel[0]};
    assign Req_A   = {t_a[1], t_a[0]};
    assign Req_B   = {t_b[1], t_b[0]};

    // Behavioural ALSU: add, increment, subtract, xor; non-arith carry driven by fc.
    function automatic logic [4:0] alsu_fn(input logic [3:0] sel, input logic [3:0] a,
                                           input logic [3:0] b, input logic f);
        logic [4:0] r;
        case (sel)
            4'b0000: r = {1'b0, a} + {1'b0, b};
            4'b1110: r = {1'b0, a} + 5'd1;
            4'b0010: r = {f, a - b};
            default: r = {f, a ^ b};
        endcase
        return r;
    endfunction

    assign {ALSU_Carry_Out, ALSU_Result} = alsu_fn(ALSU_Sel, ALSU_A, ALSU_B, fc);

    alsu_request_scheduler #(.NUM_REQ(2), .DATA_W(4), .SEL_W(4), .ALSU_LAT(1)) u_dut (
        .CLK            (clk),
        .RST            (rst),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Sel        (Req_Sel),
        .Req_A          (Req_A),
        .Req_B          (Req_B),
        .ALSU_Sel       (ALSU_Sel),
        .ALSU_A         (ALSU_A),
        .ALSU_B         (ALSU_B),
        .ALSU_Result    (ALSU_Result),
        .ALSU_Carry_Out (ALSU_Carry_Out),
        .Rsp_Valid      (Rsp_Valid),
        .Rsp_Ready      (Rsp_Ready),
        .Rsp_Id         (Rsp_Id),
        .Rsp_Result     (Rsp_Result),
        .Rsp_Carry_Out  (Rsp_Carry_Out),
`ifdef ALSU_SCHED_ZERO_FLAG_EN
        .Rsp_Zero       (Rsp_Zero),
`endif
        .Busy           (Busy)
    );

    // ---------------- ALSU_LAT=3 instance ----------------
    logic [1:0] d3_req_valid, d3_req_ready;
    logic [7:0] d3_req_sel, d3_req_a, d3_req_b;
    logic [3:0] d3_alsu_sel, d3_alsu_a, d3_alsu_b, d3_alsu_res, d3_rsp_result;
    logic       d3_alsu_co, d3_rsp_valid, d3_rsp_ready, d3_rsp_co, d3_busy;
    logic [0:0] d3_rsp_id;
`ifdef ALSU_SCHED_ZERO_FLAG_EN
    logic       d3_rsp_zero;
`endif

    assign {d3_alsu_co, d3_alsu_res} = alsu_fn(d3_alsu_sel, d3_alsu_a, d3_alsu_b, fc);

    alsu_request_scheduler #(.NUM_REQ(2), .DATA_W(4), .SEL_W(4), .ALSU_LAT(3)) u_dut3 (
        .CLK            (clk),
        .RST            (rst),
        .Req_Valid      (d3_req_valid),
        .Req_Ready      (d3_req_ready),
        .Req_Sel        (d3_req_sel),
        .Req_A          (d3_req_a),
        .Req_B          (d3_req_b),
        .ALSU_Sel       (d3_alsu_sel),
        .ALSU_A         (d3_alsu_a),
        .ALSU_B         (d3_alsu_b),
        .ALSU_Result    (d3_alsu_res),
        .ALSU_Carry_Out (d3_alsu_co),
        .Rsp_Valid      (d3_rsp_valid),
        .Rsp_Ready      (d3_rsp_ready),
        .Rsp_Id         (d3_rsp_id),
        .Rsp_Result     (d3_rsp_result),
        .Rsp_Carry_Out  (d3_rsp_co),
`ifdef ALSU_SCHED_ZERO_FLAG_EN
        .Rsp_Zero       (d3_rsp_zero),
`endif
        .Busy           (d3_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request/response transaction on the LAT=1 instance; called at posedge+1 in IDLE.
    task automatic issue(input logic [1:0] mask, input bit keep, input int hold);
        exp_t       e;
        logic       win;
        logic [4:0] r;
        int         cyc;
        Req_Valid = mask;
        Rsp_Ready = (hold == 0);
        win = mask[exp_ptr] ? exp_ptr : ~exp_ptr;
        #1;
        check("grant", 32'(Req_Ready), 32'(2'b01 << win));
        r       = alsu_fn(t_sel[win], t_a[win], t_b[win], fc);
        e.id    = win;
        e.res   = r[3:0];
        e.carry = (t_sel[win] == 4'b0000 || t_sel[win] == 4'b1110) ? r[4] : 1'b0;
        sb.push_back(e);
        step();
        if (!keep) Req_Valid = 2'b00;
        check("exec_busy", 32'(Busy), 32'(1));
        check("exec_ready", 32'(Req_Ready), 32'(0));
        check("exec_alsu_a", 32'(ALSU_A), 32'(t_a[win]));
        cyc = 1;
        while (!Rsp_Valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(2));
        for (int h = 0; h < hold; h++) begin
            check("bp_valid", 32'(Rsp_Valid), 32'(1));
            check("bp_result", 32'(Rsp_Result), 32'(sb[0].res));
            check("bp_id", 32'(Rsp_Id), 32'(sb[0].id));
            check("bp_ready", 32'(Req_Ready), 32'(0));
            check("bp_busy", 32'(Busy), 32'(1));
            step();
        end
        Rsp_Ready = 1'b1;
        e = sb.pop_front();
        check("rsp_valid", 32'(Rsp_Valid), 32'(1));
        check("rsp_id", 32'(Rsp_Id), 32'(e.id));
        check("rsp_result", 32'(Rsp_Result), 32'(e.res));
        check("rsp_carry", 32'(Rsp_Carry_Out), 32'(e.carry));
`ifdef ALSU_SCHED_ZERO_FLAG_EN
        check("rsp_zero", 32'(Rsp_Zero), 32'(e.res == 4'd0));
`endif
        step();
        check("rsp_drop", 32'(Rsp_Valid), 32'(0));
        check("idle_busy", 32'(Busy), 32'(0));
        exp_ptr = ~e.id;
    endtask

    task automatic set_op(input int idx, input logic [3:0] sel, input logic [3:0] a,
                          input logic [3:0] b);
        t_sel[idx] = sel;
        t_a[idx]   = a;
        t_b[idx]   = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fc  = 1'b0;
        exp_ptr = 1'b0;
        Req_Valid = 2'b11;
        Rsp_Ready = 1'b0;
        set_op(0, 4'd0, 4'd0, 4'd0);
        set_op(1, 4'd0, 4'd0, 4'd0);
        d3_req_valid = 2'b00;
        d3_req_sel = '0;
        d3_req_a = '0;
        d3_req_b = '0;
        d3_rsp_ready = 1'b0;

        // Reset state, with requests pending to show Req_Ready is gated.
        step();
        step();
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_rsp_valid", 32'(Rsp_Valid), 32'(0));
        check("rst_req_ready", 32'(Req_Ready), 32'(0));
        check("rst_alsu_sel", 32'(ALSU_Sel), 32'(0));
        check("rst_rsp_result", 32'(Rsp_Result), 32'(0));
        check("rst_rsp_carry", 32'(Rsp_Carry_Out), 32'(0));
        Req_Valid = 2'b00;
        rst = 1'b0;
        step();

        // Single add: 9+8 -> result 1, carry 1.
        set_op(0, 4'b0000, 4'd9, 4'd8);
        issue(2'b01, 1'b0, 0);
        // Carry masking on a non-arith op with carry forced high.
        fc = 1'b1;
        set_op(1, 4'b0101, 4'd6, 4'd3);
        issue(2'b10, 1'b0, 0);
        // Increment wraps 15 -> 0 with carry.
        set_op(0, 4'b1110, 4'd15, 4'd0);
        issue(2'b01, 1'b0, 0);
        // Backpressure: 5 cycles of Rsp_Ready low.
        set_op(1, 4'b0000, 4'd7, 4'd2);
        issue(2'b10, 1'b0, 5);
        set_op(0, 4'b0011, 4'd12, 4'd10);
        issue(2'b01, 1'b0, 0);

        // Reset during EXEC: pointer is 1 here, so requester 1 wins first.
        set_op(0, 4'b0000, 4'd1, 4'd1);
        set_op(1, 4'b0000, 4'd10, 4'd3);
        Req_Valid = 2'b11;
        #1;
        check("pre_rst_grant", 32'(Req_Ready), 32'(2'b10));
        step();
        check("pre_rst_busy", 32'(Busy), 32'(1));
        rst = 1'b1;
        step();
        check("mid_rst_busy", 32'(Busy), 32'(0));
        check("mid_rst_rsp_valid", 32'(Rsp_Valid), 32'(0));
        check("mid_rst_req_ready", 32'(Req_Ready), 32'(0));
        check("mid_rst_alsu_a", 32'(ALSU_A), 32'(0));
        check("mid_rst_alsu_b", 32'(ALSU_B), 32'(0));
        check("mid_rst_rsp_id", 32'(Rsp_Id), 32'(0));
        check("mid_rst_rsp_result", 32'(Rsp_Result), 32'(0));
        rst = 1'b0;
        exp_ptr = 1'b0;

        // Fairness: both requesters held valid -> ids 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            set_op(0, 4'b0000, 4'(k), 4'(8 + k));
            set_op(1, 4'b1110, 4'(13 + k), 4'd0);
            check("fair_ptr", 32'(exp_ptr), 32'(k % 2));
            issue(2'b11, 1'b1, 0);
        end
        Req_Valid = 2'b00;
        step();

        // ALSU_LAT=3 instance: 5-5 subtract, accept at t -> Rsp_Valid at t+4.
        d3_req_sel   = {4'd0, 4'b0010};
        d3_req_a     = {4'd0, 4'd5};
        d3_req_b     = {4'd0, 4'd5};
        d3_req_valid = 2'b01;
        d3_rsp_ready = 1'b1;
        #1;
        check("lat3_grant", 32'(d3_req_ready), 32'(2'b01));
        step();
        d3_req_valid = 2'b00;
        for (int k = 1; k < 4; k++) begin
            check("lat3_wait", 32'(d3_rsp_valid), 32'(0));
            step();
        end
        check("lat3_valid", 32'(d3_rsp_valid), 32'(1));
        check("lat3_result", 32'(d3_rsp_result), 32'(0));
        check("lat3_carry", 32'(d3_rsp_co), 32'(0));
`ifdef ALSU_SCHED_ZERO_FLAG_EN
        check("lat3_zero", 32'(d3_rsp_zero), 32'(1));
`endif
        step();
        check("lat3_drop", 32'(d3_rsp_valid), 32'(0));
        check("lat3_idle", 32'(d3_busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alsu_request_scheduler.md
Name: alsu_request_scheduler

Overview:
Shares one 4-bit ALSU between NUM_REQ requesters using round-robin arbitration. It accepts one request (Sel, A, B) at a time, drives the ALSU from registered operands, and waits ALSU_LAT cycles. It then returns the result, the carry flag and the requester ID over a valid/ready response channel. It sits between the ALSU top module and the control/test logic that issues operations.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 4, operand/result width
SEL_W, 4, ALSU operation-select width
ALSU_LAT, 1, cycles from driving ALSU inputs to a valid result (>=1)

Ports:
CLK  in  1  single clock, all state on rising edge
RST  in  1  synchronous, active-high reset
Req_Valid  in  NUM_REQ  per-requester request valid
Req_Ready  out  NUM_REQ  per-requester accept; one-hot or zero
Req_Sel  in  NUM_REQ*SEL_W  packed op selects; requester i at [i*SEL_W +: SEL_W]
Req_A  in  NUM_REQ*DATA_W  packed operand A
Req_B  in  NUM_REQ*DATA_W  packed operand B
ALSU_Sel  out  SEL_W  to ALSU
ALSU_A  out  DATA_W  to ALSU
ALSU_B  out  DATA_W  to ALSU
ALSU_Result  in  DATA_W  from ALSU
ALSU_Carry_Out  in  1  from ALSU
Rsp_Valid  out  1  response valid
Rsp_Ready  in  1  response accept
Rsp_Id  out  max(1,$clog2(NUM_REQ))  index of the granted requester
Rsp_Result  out  DATA_W  captured result
Rsp_Carry_Out  out  1  captured carry
Busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset: IDLE, RR pointer 0, all outputs 0 (ALSU_Sel/A/B, Rsp_*, Req_Ready, Busy).
- IDLE arbitration:
  - Combinational round-robin search starting at the RR pointer over Req_Valid.
  - Req_Ready is asserted only to the winner, and only in IDLE.
  - The handshake (Req_Valid & Req_Ready) registers Sel/A/B into ALSU_Sel/A/B and the winner index into Rsp_Id. Next state EXEC.
  - No valid request: remain in IDLE; ALSU outputs hold their last values.
- EXEC:
  - ALSU inputs stay stable; a latency counter runs ALSU_LAT cycles.
  - On the last EXEC cycle, capture ALSU_Result into Rsp_Result and the carry (rule below) into Rsp_Carry_Out. Next state RESP.
- Carry rule: Rsp_Carry_Out = ALSU_Carry_Out when ALSU_Sel == 4'b0000 (add) or 4'b1110 (increment); 0 for every other Sel.
- RESP:
  - Rsp_Valid=1, with Rsp_Id/Result/Carry_Out held stable until Rsp_Ready.
  - On the handshake: next IDLE, RR pointer = granted index + 1 (wraps NUM_REQ-1 -> 0), Rsp_Valid drops next cycle.
  - If Rsp_Ready is already high on the first RESP cycle, the handshake completes that cycle.
- Latency: request accept at cycle t -> Rsp_Valid at t+ALSU_LAT+1. Minimum issue interval ALSU_LAT+2 cycles.
- Requester deasserting Req_Valid while not granted: ignored, no state change.
- Simultaneous requests: exactly one grant per IDLE cycle. Repeated requests from all requesters are served strictly in rotating order; no starvation.
- RST asserted in EXEC or RESP: the in-flight op is discarded and no response is issued; the block returns to reset values on the next edge.
- Busy = (state != IDLE).

Optional Feature:
ALSU_SCHED_ZERO_FLAG_EN
- Defined: adds output Rsp_Zero (1 bit), captured with Rsp_Result; equals 1 when the captured result == 0. Reset 0, held through RESP.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package alsu_pkg:
  - SEL_W/DATA_W constants.
  - Op-select localparams SEL_ADD=4'b0000 and SEL_INC=4'b1110, also used by the carry rule.
  - State typedef {IDLE, EXEC, RESP}.
- One sub-module: rr_arbiter (NUM_REQ; inputs req vector, pointer; outputs one-hot grant, grant index, any_grant). Reused by future shared-resource blocks.

Test Plan:
- Single add: req0 Sel=0000 A=9 B=8, Rsp_Ready=1, ALSU_LAT=1 -> Rsp_Valid 2 cycles after accept, Rsp_Id=0, Result=1, Carry_Out=1.
- Carry masking: Sel=0101 with ALSU_Carry_Out forced 1 -> Rsp_Carry_Out=0. Sel=1110 A=15 -> Result=0, Carry_Out=1.
- Fairness: both requesters hold Req_Valid for 6 ops -> Rsp_Id sequence 0,1,0,1,0,1; Req_Ready never two-hot.
- Backpressure: Rsp_Ready=0 for 5 cycles in RESP -> Rsp_* stable, Req_Ready all 0, Busy=1. Raise Rsp_Ready -> IDLE next cycle.
- Reset mid-op: assert RST during EXEC -> no Rsp_Valid, all outputs 0, next grant goes to requester 0.
- ALSU_LAT=3 build: accept at t -> Rsp_Valid at t+4. With ALSU_SCHED_ZERO_FLAG_EN, A=5 B=5 subtract -> Rsp_Zero=1.
